// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter with overflow flag
// Optional leading-zero blanking: define BIN2BCD_BLANK_EN.
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [WIDTH-1:0]      BIN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  OVF
);

  localparam int NI = WIDTH / 3 + 1;
  // Accumulator is never narrower than the presented digit field.
  localparam int NA = (NI > DIGITS) ? NI : DIGITS;
  localparam int AW = 4 * NA;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    sreg_q, sreg_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic                ovf_q, ovf_d;

  logic [AW-1:0]       acc_adj;
  logic [AW-1:0]       acc_sh;
  logic [WIDTH-1:0]    sreg_sh;
  logic [4*DIGITS-1:0] res_bcd;
  logic                res_ovf;
  logic [3:0]          nib;

  always_comb begin
    acc_adj = '0;
    nib     = '0;
    for (int i = 0; i < NA; i++) begin
      nib = acc_q[4*i +: 4];
      acc_adj[4*i +: 4] = (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
    end
    acc_sh  = {acc_adj[AW-2:0], sreg_q[WIDTH-1]};
    sreg_sh = {sreg_q[WIDTH-2:0], 1'b0};

    res_ovf = 1'b0;
    for (int i = DIGITS; i < NA; i++) begin
      res_ovf = res_ovf | (|acc_sh[4*i +: 4]);
    end
    res_bcd = acc_sh[4*DIGITS-1:0];
`ifdef BIN2BCD_BLANK_EN
    begin
      logic lead;
      lead = ~res_ovf;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && (res_bcd[4*i +: 4] == 4'h0)) begin
          res_bcd[4*i +: 4] = 4'hF;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          sreg_d     = BIN;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_d  = acc_sh;
        sreg_d = sreg_sh;
        cnt_d  = CW'(cnt_q + 1'b1);
        // Last bit shifted in this cycle: publish the result directly.
        if (cnt_q == CW'(WIDTH - 1)) begin
          out_valid_d = 1'b1;
          bcd_d       = res_bcd;
          ovf_d       = res_ovf;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      sreg_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign BCD       = bcd_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - table-driven bench for bin2bcd_seq (WIDTH=8, DIGITS=2)
module tb_bin2bcd_seq;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic [7:0] BIN = 8'd0;
  logic       OUT_VALID;
  logic       OUT_READY = 1'b0;
  logic [7:0] BCD;
  logic       OVF;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef BIN2BCD_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .BIN(BIN), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .BCD(BCD), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] bin;
    logic [7:0] bcd;
    logic [7:0] bcd_blank;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Accepts one value and returns the number of cycles until OUT_VALID (99 on timeout).
  task automatic start_and_wait(input logic [7:0] b, output int lat);
    @(negedge CLK);
    BIN = b;
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    check("ready_drop", {31'd0, IN_READY}, 32'd0);
    lat = 0;
    while (!OUT_VALID && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    if (!OUT_VALID) lat = 99;
  endtask

  task automatic release_result(input logic [7:0] exp_bcd);
    OUT_READY = 1'b1;
    @(negedge CLK);
    OUT_READY = 1'b0;
    check("valid_clear", {31'd0, OUT_VALID}, 32'd0);
    check("ready_back", {31'd0, IN_READY}, 32'd1);
    check("bcd_hold", {24'd0, BCD}, {24'd0, exp_bcd});
  endtask

  initial begin
    int lat;
    int hits;
    logic [7:0] exp;

    vecs[0]  = '{8'd42,  8'h42, 8'h42, 1'b0};
    vecs[1]  = '{8'd99,  8'h99, 8'h99, 1'b0};
    vecs[2]  = '{8'd100, 8'h00, 8'h00, 1'b1};
    vecs[3]  = '{8'd255, 8'h55, 8'h55, 1'b1};
    vecs[4]  = '{8'd0,   8'h00, 8'hF0, 1'b0};
    vecs[5]  = '{8'd7,   8'h07, 8'hF7, 1'b0};
    vecs[6]  = '{8'd150, 8'h50, 8'h50, 1'b1};
    vecs[7]  = '{8'd9,   8'h09, 8'hF9, 1'b0};
    vecs[8]  = '{8'd10,  8'h10, 8'h10, 1'b0};
    vecs[9]  = '{8'd199, 8'h99, 8'h99, 1'b1};
    vecs[10] = '{8'd64,  8'h64, 8'h64, 1'b0};
    vecs[11] = '{8'd205, 8'h05, 8'h05, 1'b1};

    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
    check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
    check("rst_bcd", {24'd0, BCD}, 32'd0);
    check("rst_ovf", {31'd0, OVF}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      exp = BLANK ? vecs[i].bcd_blank : vecs[i].bcd;
      start_and_wait(vecs[i].bin, lat);
      check($sformatf("latency[%0d]", vecs[i].bin), lat, 32'd8);
      check($sformatf("bcd[%0d]", vecs[i].bin), {24'd0, BCD}, {24'd0, exp});
      check($sformatf("ovf[%0d]", vecs[i].bin), {31'd0, OVF}, {31'd0, vecs[i].ovf});
      release_result(exp);
    end

    // Backpressure: result held, IN_VALID while busy is ignored.
    start_and_wait(8'd37, lat);
    check("bp_latency", lat, 32'd8);
    for (int k = 0; k < 6; k++) begin
      IN_VALID = (k == 1);
      BIN = (k == 1) ? 8'd11 : 8'd0;
      @(negedge CLK);
      check("bp_bcd", {24'd0, BCD}, 32'h37);
      check("bp_valid", {31'd0, OUT_VALID}, 32'd1);
    end
    IN_VALID = 1'b0;
    release_result(8'h37);
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (OUT_VALID) hits++;
    end
    check("bp_no_ghost", hits, 32'd0);

    // Reset in the middle of SHIFT discards the conversion.
    @(negedge CLK);
    BIN = 8'd200;
    IN_VALID = 1'b1;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("midrst_ready", {31'd0, IN_READY}, 32'd1);
    check("midrst_valid", {31'd0, OUT_VALID}, 32'd0);
    check("midrst_bcd", {24'd0, BCD}, 32'd0);
    check("midrst_ovf", {31'd0, OVF}, 32'd0);
    hits = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge CLK);
      if (OUT_VALID) hits++;
    end
    check("midrst_no_valid", hits, 32'd0);

    // Recovery after reset converts normally.
    start_and_wait(8'd58, lat);
    check("post_rst_latency", lat, 32'd8);
    check("post_rst_bcd", {24'd0, BCD}, 32'h58);
    release_result(8'h58);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
